game_state_ctrl: RTL and testbench

Game-flow controller for the Space Invaders video subsystem. Tracks lives, remaining aliens and score from gameplay event pulses, and runs the IDLE/PLAY/HIT/LOSE/WIN state machine. Drives the registered `loser` level consumed by the game-over sprite renderer, plus `winner`, `playing` and `freeze`, which feed the win banner, sprite motion logic and HUD. It sits between the collision/alien-grid logic and the VGA sprite layer, on the 31.5 MHz pixel clock.

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_state_ctrl_if.sv | 27 ++
 rtl/hold_timer.sv | 42 ++++
 rtl/game_state_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_state_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types, widths and helpers for the Space Invaders game-flow controller.
package game_pkg;

  localparam int unsigned LIVES_W  = 3;
  localparam int unsigned ALIENS_W = 8;
  localparam int unsigned SCORE_W  = 16;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_HIT,
    ST_LOSE,
    ST_WIN
  } game_state_t;

  // Widen by one bit so a carry out can be detected and clamped.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Gameplay event inputs and game-flow status outputs of game_state_ctrl.
interface game_state_ctrl_if;
  import game_pkg::*;

  logic                start;
  logic                player_hit;
  logic                alien_killed;
  logic                alien_at_bottom;
  logic                loser;
  logic                winner;
  logic                playing;
  logic                freeze;
  logic [LIVES_W-1:0]  lives_left;
  logic [ALIENS_W-1:0] aliens_left;
  logic [SCORE_W-1:0]  score;

  modport master (
    output start, player_hit, alien_killed, alien_at_bottom,
    input  loser, winner, playing, freeze, lives_left, aliens_left, score
  );

  modport slave (
    input  start, player_hit, alien_killed, alien_at_bottom,
    output loser, winner, playing, freeze, lives_left, aliens_left, score
  );

endinterface

// File: rtl/hold_timer.sv
// Loadable down-counter; done pulses for one cycle when a loaded count has expired.
module hold_timer #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    done    = 1'b0;
    if (load) begin
      cnt_d   = load_val;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) begin
        done    = 1'b1;
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Space Invaders game-flow controller: lives, aliens, score and IDLE/PLAY/HIT/LOSE/WIN.
// Define GAME_STATE_SCORE_EN to build the saturating score accumulator; otherwise score reads 0.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_LIVES   = 3,
  parameter int unsigned NUM_ALIENS  = 40,
  parameter int unsigned HIT_HOLD    = 2000000,
  parameter int unsigned KILL_POINTS = 10
) (
  input  logic               clk,
  input  logic               rst,
  game_state_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [CNT_W-1:0]    HOLD_LOAD   = CNT_W'(HIT_HOLD - 1);
  localparam logic [LIVES_W-1:0]  LIVES_INIT  = LIVES_W'(NUM_LIVES);
  localparam logic [ALIENS_W-1:0] ALIENS_INIT = ALIENS_W'(NUM_ALIENS);

  game_state_t         state_q, state_d;
  logic                start_q;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [ALIENS_W-1:0] aliens_q, aliens_d;
  logic                loser_q, winner_q, playing_q, freeze_q;
  logic                start_rise, reload, kill_cnt;
  logic                hold_load, hold_done;

  assign start_rise = bus.start & ~start_q;
  assign reload     = start_rise & (state_q inside {ST_IDLE, ST_LOSE, ST_WIN});
  assign kill_cnt   = bus.alien_killed & (state_q inside {ST_PLAY, ST_HIT});

  // Kills are tallied independently of the transition chosen below, so a kill
  // coinciding with a LOSE or HIT transition still counts.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    aliens_d  = aliens_q;
    hold_load = 1'b0;

    if (reload) begin
      lives_d  = LIVES_INIT;
      aliens_d = ALIENS_INIT;
    end else if (kill_cnt && aliens_q != '0) begin
      aliens_d = aliens_q - ALIENS_W'(1);
    end

    unique case (state_q)
      ST_IDLE, ST_LOSE, ST_WIN: begin
        if (start_rise) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.alien_at_bottom) begin
          state_d = ST_LOSE;
          lives_d = '0;
        end else if (bus.player_hit && lives_q <= LIVES_W'(1)) begin
          state_d = ST_LOSE;
          lives_d = '0;
        end else if (bus.player_hit) begin
          state_d   = ST_HIT;
          lives_d   = lives_q - LIVES_W'(1);
          hold_load = 1'b1;
        end else if (kill_cnt && aliens_q == ALIENS_W'(1)) begin
          state_d = ST_WIN;
        end
      end
      ST_HIT: begin
        if (bus.alien_at_bottom) begin
          state_d = ST_LOSE;
        end else if (kill_cnt && aliens_q == ALIENS_W'(1)) begin
          state_d = ST_WIN;
        end else if (hold_done) begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      lives_q   <= '0;
      aliens_q  <= '0;
      loser_q   <= 1'b0;
      winner_q  <= 1'b0;
      playing_q <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      lives_q   <= lives_d;
      aliens_q  <= aliens_d;
      loser_q   <= (state_d == ST_LOSE);
      winner_q  <= (state_d == ST_WIN);
      playing_q <= (state_d == ST_PLAY) || (state_d == ST_HIT);
      freeze_q  <= (state_d == ST_HIT);
    end
  end

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .done     (hold_done)
  );

`ifdef GAME_STATE_SCORE_EN
  localparam logic [SCORE_W-1:0] KILL_INC = SCORE_W'(KILL_POINTS);

  logic [SCORE_W-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (reload) begin
      score_d = '0;
    end else if (kill_cnt) begin
      score_d = sat_add(score_q, KILL_INC);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign bus.score = score_q;
`else
  assign bus.score = '0;
`endif

  assign bus.loser       = loser_q;
  assign bus.winner      = winner_q;
  assign bus.playing     = playing_q;
  assign bus.freeze      = freeze_q;
  assign bus.lives_left  = lives_q;
  assign bus.aliens_left = aliens_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus randomized play against a game model.
module tb_game_state_ctrl;

  localparam int unsigned H  = 5;
  localparam int unsigned NL = 3;
  localparam int unsigned NA = 40;
  localparam int unsigned KP = 10;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_HIT  = 2;
  localparam int M_LOSE = 3;
  localparam int M_WIN  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .NUM_LIVES   (NL),
    .NUM_ALIENS  (NA),
    .HIT_HOLD    (H),
    .KILL_POINTS (KP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int m_mode, m_lives, m_aliens, m_score, m_hit_cycles;
  bit m_prev_start;
  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_score(input int s);
`ifdef GAME_STATE_SCORE_EN
    return s;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = 0; m_aliens = 0; m_score = 0;
    m_hit_cycles = 0; m_prev_start = 1'b0;
  endtask

  task automatic new_game();
    m_mode = M_PLAY; m_lives = NL; m_aliens = NA; m_score = 0;
  endtask

  // One clock of game rules, applied to the inputs presented at this edge.
  task automatic model_step();
    bit rise, kill, last_alien;
    if (!rst) begin
      model_reset();
      return;
    end
    rise = bus.start && !m_prev_start;
    m_prev_start = bus.start;
    kill = bus.alien_killed && (m_mode == M_PLAY || m_mode == M_HIT);
    last_alien = kill && (m_aliens == 1);
    if (kill) begin
      if (m_aliens > 0) m_aliens = m_aliens - 1;
      m_score = (m_score + KP > 65535) ? 65535 : m_score + KP;
    end
    if (m_mode == M_PLAY) begin
      if (bus.alien_at_bottom) begin
        m_mode = M_LOSE; m_lives = 0;
      end else if (bus.player_hit && m_lives == 1) begin
        m_mode = M_LOSE; m_lives = 0;
      end else if (bus.player_hit) begin
        m_mode = M_HIT; m_lives = m_lives - 1; m_hit_cycles = 1;
      end else if (last_alien) begin
        m_mode = M_WIN;
      end
    end else if (m_mode == M_HIT) begin
      if (bus.alien_at_bottom) m_mode = M_LOSE;
      else if (last_alien) m_mode = M_WIN;
      else if (m_hit_cycles == H) m_mode = M_PLAY;
      else m_hit_cycles = m_hit_cycles + 1;
    end else if (rise) begin
      new_game();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_pulse();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic hit_pulse();
    bus.player_hit = 1'b1; tick(); bus.player_hit = 1'b0;
  endtask

  task automatic kill_pulse();
    bus.alien_killed = 1'b1; tick(); bus.alien_killed = 1'b0;
  endtask

  task automatic async_reset_now();
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("loser",       bus.loser,       m_mode == M_LOSE);
      chk("winner",      bus.winner,      m_mode == M_WIN);
      chk("playing",     bus.playing,     (m_mode == M_PLAY) || (m_mode == M_HIT));
      chk("freeze",      bus.freeze,      m_mode == M_HIT);
      chk("lives_left",  bus.lives_left,  m_lives);
      chk("aliens_left", bus.aliens_left, m_aliens);
      chk("score",       bus.score,       exp_score(m_score));
    end
  end

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.player_hit = 1'b0;
    bus.alien_killed = 1'b0; bus.alien_at_bottom = 1'b0;
    model_reset();
    #12;
    chk("rst_loser",   bus.loser, 0);
    chk("rst_winner",  bus.winner, 0);
    chk("rst_playing", bus.playing, 0);
    chk("rst_freeze",  bus.freeze, 0);
    chk("rst_lives",   bus.lives_left, 0);
    chk("rst_aliens",  bus.aliens_left, 0);
    chk("rst_score",   bus.score, 0);

    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;

    // Start from reset
    start_pulse();
    chk("start_playing", bus.playing, 1);
    chk("start_lives",   bus.lives_left, 3);
    chk("start_aliens",  bus.aliens_left, 40);
    chk("start_score",   bus.score, 0);

    // Non-fatal hit with a second hit ignored during HIT
    hit_pulse();
    chk("hit_freeze", bus.freeze, 1);
    chk("hit_lives",  bus.lives_left, 2);
    tick();
    hit_pulse();
    tick_n(2);
    chk("hit_freeze_last", bus.freeze, 1);
    tick();
    chk("hit_freeze_end", bus.freeze, 0);
    chk("hit_lives_end",  bus.lives_left, 2);
    chk("hit_playing",    bus.playing, 1);

    // Win by kills
    for (int i = 0; i < 40; i++) begin
      kill_pulse();
      tick();
    end
    chk("win_winner", bus.winner, 1);
    chk("win_aliens", bus.aliens_left, 0);
    chk("win_score",  bus.score, exp_score(400));
    start_pulse();
    chk("restart_winner",  bus.winner, 0);
    chk("restart_playing", bus.playing, 1);
    chk("restart_score",   bus.score, 0);

    // Loss by three spaced hits
    for (int i = 0; i < 2; i++) begin
      hit_pulse();
      tick_n(H + 1);
    end
    hit_pulse();
    chk("loss_loser", bus.loser, 1);
    chk("loss_lives", bus.lives_left, 0);

    // Alien reaches bottom with full lives
    start_pulse();
    bus.alien_at_bottom = 1'b1; tick(); bus.alien_at_bottom = 1'b0;
    chk("bottom_loser", bus.loser, 1);

    // Final kill coincides with fatal hit
    start_pulse();
    for (int i = 0; i < 2; i++) begin
      hit_pulse();
      tick_n(H + 1);
    end
    for (int i = 0; i < 39; i++) kill_pulse();
    bus.alien_killed = 1'b1; bus.player_hit = 1'b1;
    tick();
    bus.alien_killed = 1'b0; bus.player_hit = 1'b0;
    chk("simul_loser",  bus.loser, 1);
    chk("simul_winner", bus.winner, 0);
    chk("simul_score",  bus.score, exp_score(400));

    // Asynchronous reset mid-HIT, start held across release
    start_pulse();
    hit_pulse();
    tick();
    #2;
    async_reset_now();
    #1;
    chk("arst_freeze",  bus.freeze, 0);
    chk("arst_playing", bus.playing, 0);
    chk("arst_lives",   bus.lives_left, 0);
    chk("arst_aliens",  bus.aliens_left, 0);
    bus.start = 1'b1;
    tick_n(2);
    rst = 1'b1;
    tick();
    chk("rel_playing", bus.playing, 1);
    chk("rel_lives",   bus.lives_left, 3);
    hit_pulse();
    tick_n(H + 3);
    chk("rel_lives_once", bus.lives_left, 2);
    bus.start = 1'b0;
    tick();

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      bus.player_hit      = ($urandom_range(0, 29) == 0);
      bus.alien_killed    = ($urandom_range(0, 3) == 0);
      bus.alien_at_bottom = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) bus.start = ~bus.start;
      tick();
      if ($urandom_range(0, 799) == 0) begin
        #2;
        async_reset_now();
        tick();
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
